// File: rtl/branch_target_predictor.sv
// Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB)
// with 2-bit saturating direction counters.
//  - Lookup is purely combinational on fetchPc.
//  - Mispredict detection is purely combinational on the EX resolve bundle.
//  - Table state is updated on the rising edge from the resolve bundle.
// Optional feature macro: BP_STATS_EN adds the statBranches/statMispredicts
// counters and their output ports. With the macro undefined, the block
// predicts and updates exactly as described above and has no stat ports.
module branch_target_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetchPc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        flushAll,
  input  logic        resolveValid,
  input  logic [31:0] resolvePc,
  input  logic        resolveIsJump,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTarget,
  input  logic        resolvePredTaken,
  input  logic [31:0] resolvePredTarget,
  output logic        mispredict,
  output logic [31:0] redirectPc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] statBranches,
  output logic [31:0] statMispredicts
`endif
);

  // Tag width is tied to the index width so that index + tag + the two
  // ignored byte-offset bits always cover the whole 32-bit PC.
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int DEPTH    = 1 << INDEX_BITS;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_MAX   = 2'b11;  // strongly taken
  localparam logic [1:0] CTR_MIN   = 2'b00;  // strongly not-taken

  // Table storage, one array per entry field.
  logic                r_valid  [DEPTH];
  logic [TAG_BITS-1:0] r_tag    [DEPTH];
  logic [31:0]         r_target [DEPTH];
  logic [1:0]          r_ctr    [DEPTH];

  // Fetch-side lookup signals.
  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [TAG_BITS-1:0]   w_fetch_tag;
  logic                  w_fetch_hit;

  // Resolve-side signals.
  logic [INDEX_BITS-1:0] w_res_idx;
  logic [TAG_BITS-1:0]   w_res_tag;
  logic                  w_res_hit;
  logic                  w_res_taken;
  logic                  w_dir_wrong;
  logic                  w_tgt_wrong;

  // Next contents of the entry addressed by resolvePc.
  logic                  w_upd_en;
  logic [1:0]            w_upd_ctr;
  logic [31:0]           w_upd_target;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

  // Split both PCs into index and tag; bits [1:0] take no part.
  assign w_fetch_idx = fetchPc[INDEX_BITS+1:2];
  assign w_fetch_tag = fetchPc[31:INDEX_BITS+2];
  assign w_res_idx   = resolvePc[INDEX_BITS+1:2];
  assign w_res_tag   = resolvePc[31:INDEX_BITS+2];

  // Fetch lookup: reads the current (pre-update) table contents, so a
  // same-cycle update to the same index is not bypassed.
  always_comb begin
    w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    predTaken   = w_fetch_hit && r_ctr[w_fetch_idx][1];
    predTarget  = predTaken ? r_target[w_fetch_idx] : fetchPc + 32'd4;
  end

  // Mispredict check: wrong direction, or right direction but wrong target.
  always_comb begin
    w_dir_wrong = (resolvePredTaken != resolveTaken);
    w_tgt_wrong = resolveTaken && (resolvePredTarget != resolveTarget);
    mispredict  = resolveValid && (w_dir_wrong || w_tgt_wrong);
    redirectPc  = resolveTaken ? resolveTarget : resolvePc + 32'd4;
  end

  // Decide whether and how the resolved instruction rewrites its entry.
  // Jumps are always taken, so they train the entry like a taken branch.
  // NOTE: every variable gets a default at the top of a combinational
  // block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_res_hit    = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
    w_res_taken  = resolveTaken || resolveIsJump;
    w_upd_en     = 1'b0;
    w_upd_ctr    = r_ctr[w_res_idx];
    w_upd_target = r_target[w_res_idx];
    if (resolveValid) begin
      if (w_res_hit) begin
        w_upd_en = 1'b1;
        if (resolveIsJump) begin
          w_upd_ctr = CTR_MAX;
        end else if (w_res_taken) begin
          w_upd_ctr = sat_inc(r_ctr[w_res_idx]);
        end else begin
          w_upd_ctr = sat_dec(r_ctr[w_res_idx]);
        end
        if (w_res_taken) begin
          w_upd_target = resolveTarget;
        end
      end else if (w_res_taken) begin
        // A miss allocates only when taken; not-taken misses leave the table alone.
        w_upd_en     = 1'b1;
        w_upd_ctr    = resolveIsJump ? CTR_MAX : CTR_ALLOC;
        w_upd_target = resolveTarget;
      end
    end
  end

  // Table state: async clear, flush of valid bits, or a single-entry write.
  // NOTE: the table is held in flops with async reset because a cleared
  // table must be observable immediately on rst_n, not after a sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (flushAll) begin
      // Flush drops only the valid bits and wins over any concurrent update.
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (w_upd_en) begin
      r_valid[w_res_idx]  <= 1'b1;
      r_tag[w_res_idx]    <= w_res_tag;
      r_target[w_res_idx] <= w_upd_target;
      r_ctr[w_res_idx]    <= w_upd_ctr;
    end
  end

`ifdef BP_STATS_EN
  // Event counters: free-running, wrap at 2**32, untouched by flushAll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statBranches    <= '0;
      statMispredicts <= '0;
    end else begin
      if (resolveValid) begin
        statBranches <= statBranches + 32'd1;
      end
      if (mispredict) begin
        statMispredicts <= statMispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
